// File: rtl/cache_line_pkg.sv
// Shared types and geometry helpers for the cache line port and its FIFOs.
// A line address concatenated with a word index always forms a 23-bit word address.
package cache_line_pkg;

  localparam int WADDRW = 23;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    WR_ISSUE = 2'd2,
    WR_WAIT  = 2'd3
  } state_e;

  function automatic int words_of(input int offsetwidth);
    return 2 ** (offsetwidth - 1);
  endfunction

  function automatic int line_addr_width(input int offsetwidth);
    return 24 - offsetwidth;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count.
// The head reads as zero while empty; a push while full and a pop while empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CNTW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cache_line_port.sv
// SDRAM-side responder for cache line fills and evictions: owns both transfer
// FIFOs and sequences one word command per line word to the SDRAM controller.
module cache_line_port
  import cache_line_pkg::*;
#(
  parameter int OFFSETWIDTH   = 5,
  parameter int WORDS         = words_of(OFFSETWIDTH),
  parameter int LINEADDRWIDTH = line_addr_width(OFFSETWIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     readreq,
  input  logic                     writereq,
  input  logic [LINEADDRWIDTH-1:0] rd_line_addr,
  input  logic [LINEADDRWIDTH-1:0] wr_line_addr,
  output logic                     rd_accept,
  output logic                     wr_accept,
  input  logic                     read,
  input  logic                     write,
  input  logic [15:0]              data_to_ram,
  output logic [15:0]              data_from_ram,
  output logic                     readready,
  output logic                     writeready,
  output logic                     busy,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_we,
  output logic [WADDRW-1:0]        mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [15:0]              mem_rdata
);

  localparam int IDXW = OFFSETWIDTH - 1;
  localparam int CNTW = $clog2(WORDS + 1);
  localparam logic [CNTW-1:0] WORDS_C = CNTW'(WORDS);
  localparam logic [CNTW-1:0] LAST_C  = CNTW'(WORDS - 1);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  state_e                   state_q;
  logic [LINEADDRWIDTH-1:0] line_q;
  logic [CNTW-1:0]          cmd_cnt_q, ret_cnt_q, outst_q, outst_d;
  logic                     rd_accept_q, wr_accept_q, cmd_valid_q, we_q;
  logic [WADDRW-1:0]        addr_q;

  logic                     cmd_fire, rd_push, wr_pop;
  logic [15:0]              rfifo_dout, wfifo_dout;
  logic [CNTW-1:0]          rcount, wcount;

  assign cmd_fire = cmd_valid_q && mem_cmd_ready;
  // Returns with nothing outstanding are stale (issued before a reset) and are dropped.
  assign rd_push  = mem_rvalid && (outst_q != '0) && (state_q == RD_ISSUE);
  assign wr_pop   = cmd_fire && (state_q == WR_ISSUE);

  always_comb begin
    outst_d = outst_q;
    if (cmd_fire && !we_q) outst_d = outst_d + ONE_C;
    if (rd_push)           outst_d = outst_d - ONE_C;
  end

  sync_fifo #(.WIDTH(16), .DEPTH(WORDS)) u_rd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rd_push),
    .pop   (read),
    .din   (mem_rdata),
    .dout  (rfifo_dout),
    .count (rcount)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(WORDS)) u_wr_fifo (
    .clock (clock),
    .reset (reset),
    .push  (write),
    .pop   (wr_pop),
    .din   (data_to_ram),
    .dout  (wfifo_dout),
    .count (wcount)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      line_q      <= '0;
      cmd_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
      rd_accept_q <= 1'b0;
      wr_accept_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
    end else begin
      rd_accept_q <= 1'b0;
      wr_accept_q <= 1'b0;
      outst_q     <= outst_d;
      case (state_q)
        IDLE: begin
          cmd_cnt_q <= '0;
          ret_cnt_q <= '0;
          // A fill waits for the cache to drain the previous line first.
          if (readreq && (rcount == '0)) begin
            line_q      <= rd_line_addr;
            rd_accept_q <= 1'b1;
            cmd_valid_q <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= {rd_line_addr, IDXW'(0)};
            state_q     <= RD_ISSUE;
          end else if (writereq) begin
            line_q      <= wr_line_addr;
            wr_accept_q <= 1'b1;
            state_q     <= WR_WAIT;
          end
        end
        RD_ISSUE: begin
          if (cmd_fire) begin
            cmd_cnt_q <= cmd_cnt_q + ONE_C;
            if (cmd_cnt_q == LAST_C) cmd_valid_q <= 1'b0;
            else addr_q <= {line_q, cmd_cnt_q[IDXW-1:0] + IDXW'(1)};
          end
          if (rd_push) begin
            ret_cnt_q <= ret_cnt_q + ONE_C;
            if (ret_cnt_q == LAST_C) state_q <= IDLE;
          end
        end
        WR_WAIT: begin
          if (wcount == WORDS_C) begin
            cmd_valid_q <= 1'b1;
            we_q        <= 1'b1;
            addr_q      <= {line_q, IDXW'(0)};
            state_q     <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (cmd_fire) begin
            cmd_cnt_q <= cmd_cnt_q + ONE_C;
            if (cmd_cnt_q == LAST_C) begin
              cmd_valid_q <= 1'b0;
              we_q        <= 1'b0;
              state_q     <= IDLE;
            end else begin
              addr_q <= {line_q, cmd_cnt_q[IDXW-1:0] + IDXW'(1)};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_accept     = rd_accept_q;
  assign wr_accept     = wr_accept_q;
  assign busy          = (state_q != IDLE);
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  // The write FIFO head only moves on a handshake, so write data holds through stalls.
  assign mem_wdata     = (state_q == WR_ISSUE) ? wfifo_dout : 16'h0000;
  assign data_from_ram = rfifo_dout;
  assign readready     = (rcount != '0);
  assign writeready    = (wcount != WORDS_C);

endmodule

// File: tb/tb_cache_line_port.sv
// Directed bench for cache_line_port: a small SDRAM responder returns base+word
// for each read command and logs every write command for later checking.
module tb_cache_line_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        readreq = 1'b0, writereq = 1'b0;
  logic [18:0] rd_line_addr = '0, wr_line_addr = '0;
  logic        rd_accept, wr_accept;
  logic        read = 1'b0, write = 1'b0;
  logic [15:0] data_to_ram = '0;
  logic [15:0] data_from_ram;
  logic        readready, writeready, busy, mem_cmd_valid, mem_we;
  logic        mem_cmd_ready = 1'b1;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  int          delivered  = 0;
  int          ret_limit  = 1000000;
  logic [15:0] rbase      = '0;
  bit          rdy_toggle = 1'b0;
  logic [15:0] rq[$];
  logic [22:0] ra_log[$];
  logic [22:0] wa_log[$];
  logic [15:0] wd_log[$];

  cache_line_port dut (
    .clock(clock), .reset(reset),
    .readreq(readreq), .writereq(writereq),
    .rd_line_addr(rd_line_addr), .wr_line_addr(wr_line_addr),
    .rd_accept(rd_accept), .wr_accept(wr_accept),
    .read(read), .write(write),
    .data_to_ram(data_to_ram), .data_from_ram(data_from_ram),
    .readready(readready), .writeready(writeready), .busy(busy),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin step(); n++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_delivered(input string tag, input int target);
    int n = 0;
    while (delivered < target && n < 400) begin step(); n++; end
    chk({tag, "_returns"}, 32'(delivered), 32'(target));
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    int n = 0;
    while (!readready && n < 100) begin step(); n++; end
    chk(tag, 32'(data_from_ram), 32'(exp));
    read = 1'b1;
    step();
    read = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    chk("push_room", 32'(writeready), 32'd1);
    write = 1'b1;
    data_to_ram = d;
    step();
    write = 1'b0;
  endtask

  // SDRAM responder: ready is updated before sampling so the sampled pair is
  // exactly what the DUT sees at the next rising edge.
  initial begin : responder
    logic        prev_stall;
    logic [22:0] prev_addr;
    logic [15:0] prev_wdata;
    logic        prev_we;
    int          rdy_idx;
    logic [3:0]  rdy_pat;
    prev_stall = 1'b0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
    rdy_idx = 0; rdy_pat = 4'b1001;
    forever begin
      @(negedge clock);
      if (rq.size() > 0 && delivered < ret_limit) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rq.pop_front();
        delivered++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      if (rdy_toggle) begin
        mem_cmd_ready = rdy_pat[rdy_idx];
        rdy_idx = (rdy_idx + 1) % 4;
      end else begin
        mem_cmd_ready = 1'b1;
        rdy_idx = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(mem_cmd_valid), 32'd1);
        chk("stall_addr",  32'(mem_addr),  32'(prev_addr));
        chk("stall_wdata", 32'(mem_wdata), 32'(prev_wdata));
        chk("stall_we",    32'(mem_we),    32'(prev_we));
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (mem_we) begin
          wa_log.push_back(mem_addr);
          wd_log.push_back(mem_wdata);
        end else begin
          ra_log.push_back(mem_addr);
          rq.push_back(rbase + {12'h000, mem_addr[3:0]});
        end
      end
      prev_stall = mem_cmd_valid && !mem_cmd_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_we    = mem_we;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int d0, prev_del, n;

    // Reset values
    step(); step();
    chk("rst_rd_accept", 32'(rd_accept), 32'd0);
    chk("rst_wr_accept", 32'(wr_accept), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(data_from_ram), 32'd0);
    chk("rst_readready", 32'(readready), 32'd0);
    chk("rst_writeready", 32'(writeready), 32'd1);
    reset = 1'b0;
    step();

    // Line fill at 0x1A2B3
    ra_log.delete(); rbase = 16'h1000; d0 = delivered;
    rd_line_addr = 19'h1A2B3; readreq = 1'b1;
    step();
    readreq = 1'b0;
    chk("rd_accept", 32'(rd_accept), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_first_valid", 32'(mem_cmd_valid), 32'd1);
    chk("rd_first_we", 32'(mem_we), 32'd0);
    chk("rd_first_addr", 32'(mem_addr), 32'h1A2B30);
    step();
    chk("rd_accept_pulse", 32'(rd_accept), 32'd0);
    prev_del = delivered; n = 0;
    while (busy && n < 400) begin prev_del = delivered; step(); n++; end
    chk("rd_busy_drop", 32'(busy), 32'd0);
    chk("rd_drop_after_16th", 32'(prev_del), 32'(d0 + 15));
    chk("rd_returns", 32'(delivered), 32'(d0 + 16));
    chk("rd_cmd_count", 32'(ra_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("rd_cmd_addr", 32'(ra_log[i]), 32'h1A2B30 + 32'(i));
    for (int i = 0; i < 16; i++) pop_chk("rd_data", 16'h1000 + 16'(i));
    chk("rd_drained", 32'(readready), 32'd0);

    // Eviction to 0x00040, data arrives after the accept
    wa_log.delete(); wd_log.delete();
    wr_line_addr = 19'h00040; writereq = 1'b1;
    step();
    writereq = 1'b0;
    chk("wr_accept", 32'(wr_accept), 32'd1);
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i));
    step();
    chk("wr_wait_busy", 32'(busy), 32'd1);
    chk("wr_wait_no_cmd", 32'(mem_cmd_valid), 32'd0);
    for (int i = 8; i < 16; i++) push(16'hA000 + 16'(i));
    chk("wr_full", 32'(writeready), 32'd0);
    wait_idle("wr1");
    chk("wr_cmd_count", 32'(wa_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("wr_cmd_addr", 32'(wa_log[i]), 32'h000400 + 32'(i));
      chk("wr_cmd_data", 32'(wd_log[i]), 32'hA000 + 32'(i));
    end
    chk("wr_ready_again", 32'(writeready), 32'd1);

    // Eviction with stalling controller; data pushed before the request
    wa_log.delete(); wd_log.delete();
    for (int i = 0; i < 16; i++) push(16'hB000 + 16'(i));
    chk("wr2_prefill_full", 32'(writeready), 32'd0);
    rdy_toggle = 1'b1;
    wr_line_addr = 19'h12345; writereq = 1'b1;
    step();
    writereq = 1'b0;
    chk("wr2_accept", 32'(wr_accept), 32'd1);
    wait_idle("wr2");
    rdy_toggle = 1'b0;
    chk("wr2_cmd_count", 32'(wa_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("wr2_cmd_addr", 32'(wa_log[i]), 32'h123450 + 32'(i));
      chk("wr2_cmd_data", 32'(wd_log[i]), 32'hB000 + 32'(i));
    end

    // Both requests in one cycle: read first, write after
    ra_log.delete(); wa_log.delete(); wd_log.delete();
    rbase = 16'h5000;
    rd_line_addr = 19'h01111; wr_line_addr = 19'h02222;
    readreq = 1'b1; writereq = 1'b1;
    step();
    readreq = 1'b0;
    chk("prio_rd_accept", 32'(rd_accept), 32'd1);
    chk("prio_no_wr_accept", 32'(wr_accept), 32'd0);
    n = 0;
    while (!wr_accept && n < 400) begin step(); n++; end
    writereq = 1'b0;
    chk("prio_wr_accept", 32'(wr_accept), 32'd1);
    chk("prio_read_done", 32'(ra_log.size()), 32'd16);
    chk("prio_read_full", 32'(readready), 32'd1);
    for (int i = 0; i < 16; i++) push(16'hC000 + 16'(i));
    wait_idle("prio");
    chk("prio_wr_count", 32'(wa_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("prio_wr_addr", 32'(wa_log[i]), 32'h022220 + 32'(i));
    for (int i = 0; i < 16; i++) pop_chk("prio_rd_data", 16'h5000 + 16'(i));

    // Simultaneous pop and push at count 3
    rbase = 16'h2000; d0 = delivered; ret_limit = d0 + 3;
    rd_line_addr = 19'h00ABC; readreq = 1'b1;
    step();
    readreq = 1'b0;
    wait_delivered("sim3", d0 + 3);
    step();
    chk("sim3_head", 32'(data_from_ram), 32'h2000);
    ret_limit = d0 + 4; read = 1'b1;
    step();
    read = 1'b0;
    chk("sim3_push_seen", 32'(delivered), 32'(d0 + 4));
    for (int i = 1; i < 4; i++) pop_chk("sim3_data", 16'h2000 + 16'(i));
    chk("sim3_count_kept", 32'(readready), 32'd0);
    ret_limit = 1000000;
    wait_idle("sim3");
    for (int i = 4; i < 16; i++) pop_chk("sim3_rest", 16'h2000 + 16'(i));

    // Reset after seven returns
    ra_log.delete(); rbase = 16'h3000; d0 = delivered; ret_limit = d0 + 7;
    rd_line_addr = 19'h0BEEF; readreq = 1'b1;
    step();
    readreq = 1'b0;
    wait_delivered("rst7", d0 + 7);
    step();
    chk("rst7_pre_ready", 32'(readready), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst7_busy", 32'(busy), 32'd0);
    chk("rst7_readready", 32'(readready), 32'd0);
    chk("rst7_writeready", 32'(writeready), 32'd1);
    chk("rst7_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    step();
    reset = 1'b0;
    ret_limit = 1000000;
    repeat (24) step();
    chk("rst7_stale_dropped", 32'(readready), 32'd0);
    chk("rst7_still_idle", 32'(busy), 32'd0);
    ra_log.delete(); rbase = 16'h4000;
    readreq = 1'b1;
    step();
    readreq = 1'b0;
    chk("rst7_restart_addr", 32'(mem_addr), 32'h0BEEF0);
    wait_idle("rst7");
    chk("rst7_cmd_count", 32'(ra_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) pop_chk("rst7_data", 16'h4000 + 16'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
